// File: rtl/spi_byte_fifo.sv
// TX/RX byte FIFOs between the 6502 register interface and the SPI shifter.
// Optional registered interrupt output is built when SPI_FIFO_IRQ_EN is defined.
module spi_byte_fifo #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic       clock_spi,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       bus_wr,
    input  logic [7:0] bus_wdata,
    input  logic       bus_rd,
    output logic [7:0] bus_rdata,
    output logic [7:0] status,
    output logic       tx_valid,
    output logic [7:0] tx_data,
    input  logic       tx_ready,
    input  logic       rx_valid,
    input  logic [7:0] rx_data
`ifdef SPI_FIFO_IRQ_EN
    ,
    input  logic [1:0] irq_mask,
    output logic       irq_n
`endif
);

    localparam logic [DEPTH_LOG2:0] DEPTH = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);

    logic [7:0]            tx_mem [2**DEPTH_LOG2];
    logic [7:0]            rx_mem [2**DEPTH_LOG2];
    logic [DEPTH_LOG2-1:0] tx_rd_ptr, tx_wr_ptr, rx_rd_ptr, rx_wr_ptr;
    logic [DEPTH_LOG2:0]   tx_count, rx_count;
    logic                  tx_ovf, rx_ovf;
    logic                  tx_full, tx_empty, rx_full, rx_empty;
    logic                  tx_push, tx_pop, rx_push, rx_pop;
    logic                  irq_pend;

    // All accept/reject decisions come from the pre-edge counts.
    assign tx_full  = (tx_count == DEPTH);
    assign tx_empty = (tx_count == '0);
    assign rx_full  = (rx_count == DEPTH);
    assign rx_empty = (rx_count == '0);

    assign tx_push = bus_wr   & ~tx_full;
    assign tx_pop  = tx_ready & ~tx_empty;
    assign rx_push = rx_valid & ~rx_full;
    assign rx_pop  = bus_rd   & ~rx_empty;

    always_ff @(posedge clock_spi) begin
        if (tx_push)
            tx_mem[tx_wr_ptr] <= bus_wdata;
        if (rx_push)
            rx_mem[rx_wr_ptr] <= rx_data;
    end

    always_ff @(posedge clock_spi) begin
        if (!reset_n || clear) begin
            tx_rd_ptr <= '0;
            tx_wr_ptr <= '0;
            tx_count  <= '0;
            tx_ovf    <= 1'b0;
        end else begin
            if (tx_push)
                tx_wr_ptr <= tx_wr_ptr + 1'b1;
            if (tx_pop)
                tx_rd_ptr <= tx_rd_ptr + 1'b1;
            case ({tx_push, tx_pop})
                2'b10:   tx_count <= tx_count + 1'b1;
                2'b01:   tx_count <= tx_count - 1'b1;
                default: tx_count <= tx_count;
            endcase
            if (bus_wr && tx_full)
                tx_ovf <= 1'b1;
        end
    end

    always_ff @(posedge clock_spi) begin
        if (!reset_n || clear) begin
            rx_rd_ptr <= '0;
            rx_wr_ptr <= '0;
            rx_count  <= '0;
            rx_ovf    <= 1'b0;
        end else begin
            if (rx_push)
                rx_wr_ptr <= rx_wr_ptr + 1'b1;
            if (rx_pop)
                rx_rd_ptr <= rx_rd_ptr + 1'b1;
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
            if (rx_valid && rx_full)
                rx_ovf <= 1'b1;
        end
    end

    // Heads read as zero when empty so stale RAM contents never leak out.
    assign tx_valid  = ~tx_empty;
    assign tx_data   = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr];
    assign bus_rdata = rx_empty ? 8'h00 : rx_mem[rx_rd_ptr];

`ifdef SPI_FIFO_IRQ_EN
    always_ff @(posedge clock_spi) begin
        if (!reset_n)
            irq_n <= 1'b1;
        else
            irq_n <= ~((irq_mask[0] & ~rx_empty) | (irq_mask[1] & tx_empty));
    end

    assign irq_pend = ~irq_n;
`else
    assign irq_pend = 1'b0;
`endif

    assign status = {tx_full, tx_empty, rx_full, rx_empty, tx_ovf, rx_ovf, irq_pend, 1'b0};

endmodule

// File: tb/tb_spi_byte_fifo.sv
// Self-checking bench for spi_byte_fifo: directed cases then random traffic
// against a queue-based reference model.
module tb_spi_byte_fifo;

    logic       clock_spi = 1'b0;
    logic       reset_n   = 1'b0;
    logic       clear     = 1'b0;
    logic       bus_wr    = 1'b0;
    logic [7:0] bus_wdata = 8'h00;
    logic       bus_rd    = 1'b0;
    logic [7:0] bus_rdata;
    logic [7:0] status;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready  = 1'b0;
    logic       rx_valid  = 1'b0;
    logic [7:0] rx_data   = 8'h00;
    logic [1:0] irq_mask  = 2'b00;
    logic       irq_n;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [7:0] tq[$];
    logic [7:0] rq[$];
    logic       m_tx_ovf = 1'b0;
    logic       m_rx_ovf = 1'b0;
    logic       m_irq_n  = 1'b1;

    spi_byte_fifo dut (
        .clock_spi (clock_spi),
        .reset_n   (reset_n),
        .clear     (clear),
        .bus_wr    (bus_wr),
        .bus_wdata (bus_wdata),
        .bus_rd    (bus_rd),
        .bus_rdata (bus_rdata),
        .status    (status),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data)
`ifdef SPI_FIFO_IRQ_EN
        ,
        .irq_mask  (irq_mask),
        .irq_n     (irq_n)
`endif
    );

`ifndef SPI_FIFO_IRQ_EN
    assign irq_n = 1'b1;
`endif

    always #5 clock_spi = ~clock_spi;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the model by one rising edge using the pre-edge queue sizes.
    task automatic modelEdge();
        bit tx_full_pre, tx_empty_pre, rx_full_pre, rx_empty_pre;
        tx_full_pre  = (tq.size() == 8);
        tx_empty_pre = (tq.size() == 0);
        rx_full_pre  = (rq.size() == 8);
        rx_empty_pre = (rq.size() == 0);
        if (!reset_n) begin
            m_irq_n = 1'b1;
        end else begin
            m_irq_n = !((irq_mask[0] && !rx_empty_pre) || (irq_mask[1] && tx_empty_pre));
        end
`ifndef SPI_FIFO_IRQ_EN
        m_irq_n = 1'b1;
`endif
        if (!reset_n || clear) begin
            tq.delete();
            rq.delete();
            m_tx_ovf = 1'b0;
            m_rx_ovf = 1'b0;
        end else begin
            if (tx_ready && !tx_empty_pre) void'(tq.pop_front());
            if (bus_wr) begin
                if (tx_full_pre) m_tx_ovf = 1'b1;
                else             tq.push_back(bus_wdata);
            end
            if (bus_rd && !rx_empty_pre) void'(rq.pop_front());
            if (rx_valid) begin
                if (rx_full_pre) m_rx_ovf = 1'b1;
                else             rq.push_back(rx_data);
            end
        end
    endtask

    task automatic compareAll();
        logic [7:0] exp_status;
        exp_status = {tq.size() == 8, tq.size() == 0, rq.size() == 8, rq.size() == 0,
                      m_tx_ovf, m_rx_ovf, !m_irq_n, 1'b0};
        checkOutput("tx_valid",  tx_valid,  tq.size() != 0);
        checkOutput("tx_data",   tx_data,   tq.size() != 0 ? tq[0] : 8'h00);
        checkOutput("bus_rdata", bus_rdata, rq.size() != 0 ? rq[0] : 8'h00);
        checkOutput("status",    status,    exp_status);
        checkOutput("irq_n",     irq_n,     m_irq_n);
    endtask

    // Drive one cycle of inputs, clock it, update the model and check on the falling edge.
    task automatic applyStimulus(input logic wr, input logic [7:0] wdata, input logic rd,
                                 input logic rdy, input logic rxv, input logic [7:0] rxd,
                                 input logic clr);
        bus_wr    = wr;
        bus_wdata = wdata;
        bus_rd    = rd;
        tx_ready  = rdy;
        rx_valid  = rxv;
        rx_data   = rxd;
        clear     = clr;
        @(posedge clock_spi);
        modelEdge();
        @(negedge clock_spi);
        bus_wr   = 1'b0;
        bus_rd   = 1'b0;
        tx_ready = 1'b0;
        rx_valid = 1'b0;
        clear    = 1'b0;
        compareAll();
    endtask

    task automatic idle();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        @(negedge clock_spi);
        // Reset held for two cycles
        reset_n = 1'b0;
        idle();
        idle();
        reset_n = 1'b1;
        checkOutput("reset_status", status, 8'h50);
        checkOutput("reset_tx_valid", tx_valid, 1'b0);
        checkOutput("reset_rdata", bus_rdata, 8'h00);
        checkOutput("reset_tx_data", tx_data, 8'h00);

        // TX ordering
        applyStimulus(1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("tx_first_latency", tx_valid, 1'b1);
        applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("tx_head_a5", tx_data, 8'hA5);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("tx_head_3c", tx_data, 8'h3C);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("tx_drained_valid", tx_valid, 1'b0);
        checkOutput("tx_drained_empty", status[6], 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // TX overflow: ninth push is dropped
        for (int i = 1; i <= 9; i++)
            applyStimulus(1'b1, 8'(i), 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("tx_full", status[7], 1'b1);
        checkOutput("tx_ovf", status[3], 1'b1);
        // Push while full with a same-cycle pop is still rejected
        applyStimulus(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("tx_full_push_pop", status[7], 1'b0);
        for (int i = 2; i <= 8; i++) begin
            checkOutput("tx_drain_order", tx_data, 32'(i));
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        end
        checkOutput("tx_after_drain", tx_valid, 1'b0);

        // RX path
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hAA, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0);
        checkOutput("rx_head_aa", bus_rdata, 8'hAA);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("rx_head_55", bus_rdata, 8'h55);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("rx_empty_rdata", bus_rdata, 8'h00);
        checkOutput("rx_empty_flag", status[4], 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        // Simultaneous push and pop on an empty RX: push only
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h11, 1'b0);
        checkOutput("rx_empty_push_pop", bus_rdata, 8'h11);

        // Simultaneous push/pop with three entries
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h22, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h33, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h44, 1'b0);
        checkOutput("rx_simul_head", bus_rdata, 8'h22);
        checkOutput("rx_simul_count", rq.size(), 3);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'(8'h50 + i), 1'b0);
        checkOutput("rx_full", status[5], 1'b1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hFF, 1'b0);
        checkOutput("rx_ovf", status[2], 1'b1);
        checkOutput("rx_keep_head", bus_rdata, 8'h22);

        // clear beats same-cycle push and strobe
        applyStimulus(1'b1, 8'h77, 1'b1, 1'b1, 1'b1, 8'h88, 1'b1);
        checkOutput("clear_status", status, 8'h50);

`ifdef SPI_FIFO_IRQ_EN
        irq_mask = 2'b01;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h99, 1'b0);
        checkOutput("irq_not_yet", irq_n, 1'b1);
        idle();
        checkOutput("irq_low", irq_n, 1'b0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
`endif

        // Random traffic with occasional clear and reset
        for (int n = 0; n < 600; n++) begin
`ifdef SPI_FIFO_IRQ_EN
            irq_mask = 2'($urandom);
`endif
            reset_n = ($urandom_range(0, 99) != 0);
            applyStimulus(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45),
                          1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 55), 8'($urandom),
                          1'($urandom_range(0, 99) < 2));
        end
        reset_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
